// File: rtl/rf_write_arbiter_if.sv
// Writeback request bus between requesters and the regfile write arbiter.
// Carries per-requester valid/ready/addr/data plus the two regfile write ports.
interface rf_write_arbiter_if #(
    parameter int addr_w = 5,
    parameter int data_w = 32,
    parameter int n_req  = 3
);
    logic                      stall;
    logic [n_req-1:0]          req_valid;
    logic [n_req*addr_w-1:0]   req_addr;
    logic [n_req*data_w-1:0]   req_data;
    logic [n_req-1:0]          req_ready;
    logic [addr_w-1:0]         RdAddr0;
    logic [data_w-1:0]         RdData0;
    logic [addr_w-1:0]         RdAddr1;
    logic [data_w-1:0]         RdData1;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready, RdAddr0, RdData0, RdAddr1, RdData1
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready, RdAddr0, RdData0, RdAddr1, RdData1
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter granting up to two distinct-register writes per cycle
// onto the two regfile write ports, registered with one cycle of latency.
module rf_write_arbiter #(
    parameter int addr_w = 5,
    parameter int data_w = 32,
    parameter int n_req  = 3
) (
    input logic              clk,
    input logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int pw  = $clog2(n_req);
    localparam int pw1 = pw + 1;
    localparam logic [pw:0] nr = pw1'(n_req);

    logic [pw-1:0]     ptr;
    logic [pw-1:0]     a_idx;
    logic [pw-1:0]     b_idx;
    logic [pw-1:0]     j;
    logic              a_hit;
    logic              b_hit;
    logic              go;
    logic [addr_w-1:0] cur;
    logic [addr_w-1:0] a_addr;
    logic [addr_w-1:0] b_addr;
    logic [data_w-1:0] a_data;
    logic [data_w-1:0] b_data;
    logic [n_req-1:0]  ready;
    logic [addr_w-1:0] rd_addr0;
    logic [data_w-1:0] rd_data0;
    logic [addr_w-1:0] rd_addr1;
    logic [data_w-1:0] rd_data1;

    // Sums of two indices are below 2*n_req, so one subtraction wraps them.
    function automatic logic [pw-1:0] wrap(input logic [pw:0] x);
        logic [pw:0] y;
        y = (x >= nr) ? x - nr : x;
        return y[pw-1:0];
    endfunction

    assign go            = !bus.stall && !rst;
    assign bus.req_ready = ready;
    assign bus.RdAddr0   = rd_addr0;
    assign bus.RdData0   = rd_data0;
    assign bus.RdAddr1   = rd_addr1;
    assign bus.RdData1   = rd_data1;

    // Scan from ptr: first nonzero request is A, next one to another register is B.
    always_comb begin
        ready  = '0;
        a_hit  = 1'b0;
        b_hit  = 1'b0;
        a_idx  = '0;
        b_idx  = '0;
        a_addr = '0;
        b_addr = '0;
        a_data = '0;
        b_data = '0;
        j      = '0;
        cur    = '0;
        for (int k = 0; k < n_req; k++) begin
            j   = wrap({1'b0, ptr} + pw1'(k));
            cur = bus.req_addr[int'(j)*addr_w +: addr_w];
            if (go && bus.req_valid[j]) begin
                if (cur == '0) begin
                    ready[j] = 1'b1;
                end else if (!a_hit) begin
                    a_hit    = 1'b1;
                    a_idx    = j;
                    a_addr   = cur;
                    a_data   = bus.req_data[int'(j)*data_w +: data_w];
                    ready[j] = 1'b1;
                end else if (!b_hit && cur != a_addr) begin
                    b_hit    = 1'b1;
                    b_idx    = j;
                    b_addr   = cur;
                    b_data   = bus.req_data[int'(j)*data_w +: data_w];
                    ready[j] = 1'b1;
                end
            end
        end
    end

    // Register the grants onto the write ports and advance past the last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            rd_addr0 <= '0;
            rd_data0 <= '0;
            rd_addr1 <= '0;
            rd_data1 <= '0;
        end else begin
            rd_addr0 <= a_hit ? a_addr : '0;
            rd_data0 <= a_hit ? a_data : '0;
            rd_addr1 <= b_hit ? b_addr : '0;
            rd_data1 <= b_hit ? b_data : '0;
            if (b_hit) begin
                ptr <= wrap({1'b0, b_idx} + pw1'(1));
            end else if (a_hit) begin
                ptr <= wrap({1'b0, a_idx} + pw1'(1));
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model
// predicts ready and next-cycle port contents; a monitor pops and compares.
module tb_rf_write_arbiter;
    typedef struct {
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic mon_en;
    logic [1:0] mptr;
    exp_t q[$];
    logic [31:0] obs_rf [32];

    rf_write_arbiter_if #(.addr_w(5), .data_w(32), .n_req(3)) bus ();

    rf_write_arbiter #(.addr_w(5), .data_w(32), .n_req(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: list requesters in scan order, drop x0 writes, A is the first
    // remaining, B the first later one targeting a different register.
    function automatic void model(input logic [1:0] p, input logic st,
                                  input logic [2:0] v, input logic [14:0] a,
                                  input logic [95:0] d, output logic [2:0] rdy,
                                  output exp_t e, output logic [1:0] np);
        int order[$];
        int nz[$];
        int ga;
        int gb;
        int last;
        rdy = '0;
        e   = '{a0: '0, d0: '0, a1: '0, d1: '0};
        np  = p;
        if (st) return;
        for (int k = 0; k < 3; k++) order.push_back((int'(p) + k) % 3);
        foreach (order[n]) begin
            if (v[order[n]]) begin
                if (a[order[n]*5 +: 5] == 5'd0) rdy[order[n]] = 1'b1;
                else nz.push_back(order[n]);
            end
        end
        if (nz.size() == 0) return;
        ga = nz[0];
        gb = -1;
        for (int n = 1; n < nz.size(); n++) begin
            if (gb < 0 && a[nz[n]*5 +: 5] != a[ga*5 +: 5]) gb = nz[n];
        end
        rdy[ga] = 1'b1;
        e.a0 = a[ga*5 +: 5];
        e.d0 = d[ga*32 +: 32];
        last = ga;
        if (gb >= 0) begin
            rdy[gb] = 1'b1;
            e.a1 = a[gb*5 +: 5];
            e.d1 = d[gb*32 +: 32];
            last = gb;
        end
        np = 2'((last + 1) % 3);
    endfunction

    // Called at a falling edge; drives one cycle of requests.
    task automatic step(input logic st, input logic [2:0] v,
                        input logic [14:0] a, input logic [95:0] d);
        logic [2:0] rdy;
        exp_t e;
        logic [1:0] np;
        bus.stall     = st;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        #1;
        model(mptr, st, v, a, d, rdy, e, np);
        check("ready", 64'(bus.req_ready), 64'(rdy));
        check("ptr", 64'(dut.ptr), 64'(mptr));
        q.push_back(e);
        mptr = np;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor queue empty");
            end else begin
                e = q.pop_front();
                check("rdaddr0", 64'(bus.RdAddr0), 64'(e.a0));
                check("rddata0", 64'(bus.RdData0), 64'(e.d0));
                check("rdaddr1", 64'(bus.RdAddr1), 64'(e.a1));
                check("rddata1", 64'(bus.RdData1), 64'(e.d1));
                if (bus.RdAddr0 != 5'd0 && bus.RdAddr0 == bus.RdAddr1) begin
                    checks++;
                    errors++;
                    $display("FAIL same_addr both=%0d", bus.RdAddr0);
                end
                if (bus.RdAddr0 != 5'd0) obs_rf[bus.RdAddr0] = bus.RdData0;
                if (bus.RdAddr1 != 5'd0) obs_rf[bus.RdAddr1] = bus.RdData1;
            end
        end
    end

    initial begin
        logic [14:0] ra;
        logic [95:0] rd;
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        mptr   = 2'd0;
        for (int i = 0; i < 32; i++) obs_rf[i] = 32'd0;
        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'd3, 32'd2, 32'd1};
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_addr0", 64'(bus.RdAddr0), 64'd0);
        check("rst_addr1", 64'(bus.RdAddr1), 64'd0);
        check("rst_data0", 64'(bus.RdData0), 64'd0);
        check("rst_ptr", 64'(dut.ptr), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single write from requester 0
        step(0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hAA});
        // Bring pointer back to 0
        step(0, 3'b100, {5'd1, 5'd0, 5'd0}, {32'h11, 32'd0, 32'd0});
        // Three distinct writes: two granted, third next cycle
        step(0, 3'b111, {5'd6, 5'd4, 5'd3}, {32'h6, 32'h4, 32'h3});
        step(0, 3'b100, {5'd6, 5'd0, 5'd0}, {32'h6, 32'd0, 32'd0});
        // Same register collision retires in scan order
        step(0, 3'b011, {5'd0, 5'd7, 5'd7}, {32'd0, 32'd2, 32'd1});
        step(0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'd2, 32'd0});
        step(0, 3'b000, 15'd0, 96'd0);
        check("rf_x7_final", 64'(obs_rf[7]), 64'd2);
        // x0 write discarded alongside a real write
        step(0, 3'b110, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h55, 32'd0});
        // Stall blocks everything
        step(1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1});
        // Persistent all-valid rotation
        repeat (6) step(0, 3'b111, {5'd12, 5'd11, 5'd10},
                        {32'hC, 32'hB, 32'hA});

        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 3; i++) begin
                ra[i*5 +: 5] = ($urandom_range(0, 3) == 0) ?
                               5'($urandom_range(0, 31)) :
                               5'($urandom_range(0, 3));
                rd[i*32 +: 32] = $urandom;
            end
            step(($urandom_range(0, 7) == 0), 3'($urandom), ra, rd);
        end

        // Reset asserted mid-cycle with a grant pending
        bus.stall     = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, 5'd5};
        bus.req_data  = {32'd0, 32'd0, 32'h77};
        #2;
        rst    = 1'b1;
        mon_en = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        check("midrst_addr0", 64'(bus.RdAddr0), 64'd0);
        check("midrst_ptr", 64'(dut.ptr), 64'd0);
        check("midrst_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst           = 1'b0;
        mptr          = 2'd0;
        bus.req_valid = 3'b000;
        mon_en        = 1'b1;
        step(0, 3'b000, 15'd0, 96'd0);
        // First grant after reset scans from requester 0
        step(0, 3'b011, {5'd0, 5'd8, 5'd8}, {32'd0, 32'h2, 32'h1});
        step(0, 3'b000, 15'd0, 96'd0);
        step(0, 3'b000, 15'd0, 96'd0);
        mon_en = 1'b0;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
